branch_resolve_unit: RTL

EX-stage branch resolver and predictor-update source for the 5-stage RISC-V pipeline. It evaluates conditional branches using forwarded operands and compares the outcome with the prediction carried down the ID/EX register (taken flag, target, 2-bit state). On a mispredict it issues a registered PC redirect and squashes the wrong path. It queues predictor training updates through a 2-entry FIFO with a valid/ready handshake, so it is the write side of the `branch_predictor` that IF reads.

---
 rtl/branch_resolve_unit.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - EX-stage branch resolver with PC redirect and predictor update queue
module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic [XLEN-1:0]  ex_rs1_val,
  input  logic [XLEN-1:0]  ex_rs2_val,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_target,
  input  logic [1:0]       ex_bp_state,
  output logic             stall_req,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             upd_valid,
  input  logic             upd_ready,
  output logic [XLEN-1:0]  upd_pc,
  output logic [XLEN-1:0]  upd_target,
  output logic             upd_taken,
  output logic [1:0]       upd_state,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  typedef enum logic {RUN, SQUASH} state_t;
  state_t state_q, state_d;

  logic            legal, actual, mispredict, consume, pop;
  logic [1:0]      new_state;
  logic [XLEN-1:0] target, fallthrough;

  logic [1:0][XLEN-1:0] f_pc, f_tgt;
  logic [1:0]           f_taken;
  logic [1:0][1:0]      f_state;
  logic                 rd_ptr, wr_ptr;
  logic [1:0]           count;
  logic [XLEN-1:0]      redirect_pc_q;
  logic [CNT_W-1:0]     br_q, mis_q;

  assign target      = ex_pc + ex_imm;
  assign fallthrough = ex_pc + XLEN'(4);

  always_comb begin
    legal  = 1'b1;
    actual = 1'b0;
    case (ex_funct3)
      3'b000:  actual = (ex_rs1_val == ex_rs2_val);
      3'b001:  actual = (ex_rs1_val != ex_rs2_val);
      3'b100:  actual = ($signed(ex_rs1_val) <  $signed(ex_rs2_val));
      3'b101:  actual = ($signed(ex_rs1_val) >= $signed(ex_rs2_val));
      3'b110:  actual = (ex_rs1_val <  ex_rs2_val);
      3'b111:  actual = (ex_rs1_val >= ex_rs2_val);
      default: legal  = 1'b0;
    endcase
  end

  always_comb begin
    new_state = ex_bp_state;
    if (actual && ex_bp_state != 2'b11)
      new_state = ex_bp_state + 2'd1;
    else if (!actual && ex_bp_state != 2'b00)
      new_state = ex_bp_state - 2'd1;
  end

  assign mispredict = (actual != ex_pred_taken) ||
                      (actual && ex_pred_taken && (ex_pred_target != target));

  // Full queue and wrong-path occupancy both block resolution
  assign stall_req = (count == 2'd2);
  assign consume   = (state_q == RUN) && ex_valid && ex_branch && legal && !stall_req;
  assign upd_valid = (count != 2'd0);
  assign pop       = upd_valid && upd_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (consume && mispredict) state_d = SQUASH;
      SQUASH:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= RUN;
      f_pc          <= '0;
      f_tgt         <= '0;
      f_taken       <= '0;
      f_state       <= '0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      count         <= 2'd0;
      redirect_pc_q <= '0;
      br_q          <= '0;
      mis_q         <= '0;
    end else begin
      state_q <= state_d;
      if (consume) begin
        f_pc[wr_ptr]    <= ex_pc;
        f_tgt[wr_ptr]   <= target;
        f_taken[wr_ptr] <= actual;
        f_state[wr_ptr] <= new_state;
        wr_ptr          <= ~wr_ptr;
        if (mispredict)
          redirect_pc_q <= actual ? target : fallthrough;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, consume} - {1'b0, pop};
      if (cnt_clr) begin
        br_q  <= '0;
        mis_q <= '0;
      end else if (consume) begin
        br_q <= br_q + CNT_W'(1);
        if (mispredict)
          mis_q <= mis_q + CNT_W'(1);
      end
    end
  end

  assign redirect_valid = (state_q == SQUASH);
  assign flush_if_id    = (state_q == SQUASH);
  assign flush_id_ex    = (state_q == SQUASH);
  assign redirect_pc    = redirect_pc_q;
  assign upd_pc         = f_pc[rd_ptr];
  assign upd_target     = f_tgt[rd_ptr];
  assign upd_taken      = f_taken[rd_ptr];
  assign upd_state      = f_state[rd_ptr];
  assign br_count       = br_q;
  assign mispred_count  = mis_q;

endmodule
